// File: rtl/qr_tx_pkg.sv
// Shared types and constants for the quarter-rate TX feed controller.
// This covers the FSM state and pattern encodings, fixed nibbles and the PRBS7 helper.
package qr_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_ALT   = 2'd0,
    PAT_PRBS7 = 2'd1,
    PAT_ONES  = 2'd2,
    PAT_ALT_B = 2'd3
  } pat_t;

  localparam logic [3:0] IDLE_NIB   = 4'b0000;
  localparam logic [3:0] ALT_NIB    = 4'b1010;
  localparam logic [3:0] ONES_NIB   = 4'b1111;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  // The upper field is the advanced state. The lower field is the 4 bits generated, first bit in [0].
  function automatic logic [10:0] prbs7_adv4(input logic [6:0] seed);
    logic [6:0] s;
    logic [3:0] nib;
    s   = seed;
    nib = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      nib[i] = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
      s      = {s[5:0], nib[i]};
    end
    return {s, nib};
  endfunction

  function automatic logic [3:0] pat_nib(input pat_t pat, input logic [3:0] prbs_nib);
    logic [3:0] nib;
    case (pat)
      PAT_PRBS7: nib = prbs_nib;
      PAT_ONES:  nib = ONES_NIB;
      PAT_ALT:   nib = ALT_NIB;
      PAT_ALT_B: nib = ALT_NIB;
      default:   nib = ALT_NIB;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/qr_prbs7_4b.sv
// PRBS7 generator advancing four bits per clock.
// o_nib is the nibble the current state will produce on the next advance.
module qr_prbs7_4b
  import qr_tx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [3:0] o_nib
);

  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_nxt;
  logic [3:0] w_nib;

  assign {w_lfsr_nxt, w_nib} = prbs7_adv4(r_lfsr);
  assign o_nib = w_nib;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_load) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_adv) begin
      r_lfsr <= w_lfsr_nxt;
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

endmodule

// File: rtl/qr_tx_feed_ctrl.sv
// Feed controller for the quarter-rate 4:1 TX mux. Each cycle it drives idle, training or payload nibbles.
// Payload words pass through a word-to-nibble gearbox, and retrains are taken only at word boundaries.
module qr_tx_feed_ctrl
  import qr_tx_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_train_req,
  input  logic [CNT_W-1:0]  i_train_len,
  input  logic [1:0]        i_pat_sel,
  input  logic [WORD_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [3:0]        o_din,
  output logic [1:0]        o_state,
  output logic              o_underflow,
  input  logic              i_clr_underflow
);

  localparam int NIB_N = WORD_W / 4;
  localparam int IDX_W = $clog2(NIB_N);
  localparam logic [IDX_W-1:0] NIB_LAST = IDX_W'(NIB_N - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  pat_t               r_pat;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_pend;
  logic [3:0]         r_din;
  logic               r_s_ready;
  logic               r_underflow;

  logic [3:0]         w_din_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_enter;
  logic               w_uf_set;
  logic               w_prbs_adv;
  logic [3:0]         w_prbs_nib;
  logic               w_busy_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_pend_nxt;
  logic               w_ready_nxt;
  logic               w_hs;
  logic               w_boundary;
  logic               w_retrain_req;
  logic               w_train_step;

  assign w_hs          = i_s_valid & r_s_ready;
  // A word boundary is either an empty gearbox or its last nibble currently on din.
  assign w_boundary    = ~r_busy | (r_idx == NIB_LAST);
  assign w_retrain_req = r_pend | i_train_req;
  assign w_train_step  = i_en & (r_state == ST_TRAIN);

  qr_prbs7_4b u_prbs (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_enter),
    .i_adv  (w_prbs_adv),
    .o_nib  (w_prbs_nib)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = i_train_req ? ST_TRAIN : ST_IDLE;
        ST_TRAIN: w_state_nxt = (r_cnt <= CNT_W'(1)) ? ST_DATA : ST_TRAIN;
        ST_DATA:  w_state_nxt = (!w_hs && w_boundary && w_retrain_req) ? ST_TRAIN : ST_DATA;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_din_nxt  = IDLE_NIB;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_enter    = 1'b0;
    w_uf_set   = 1'b0;
    w_prbs_adv = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          w_enter = i_train_req;
        end
        ST_TRAIN: begin
          w_din_nxt  = pat_nib(r_pat, w_prbs_nib);
          w_prbs_adv = (r_pat == PAT_PRBS7);
        end
        ST_DATA: begin
          // A handshake always wins, so an accepted word is never dropped by a retrain.
          if (w_hs) begin
            w_load    = 1'b1;
            w_din_nxt = i_s_data[3:0];
          end else if (!w_boundary) begin
            w_shift   = 1'b1;
            w_din_nxt = r_word[3:0];
          end else if (w_retrain_req) begin
            w_enter   = 1'b1;
          end else begin
            w_uf_set  = 1'b1;
          end
        end
        default: begin
          w_din_nxt = IDLE_NIB;
        end
      endcase
    end else begin
      w_din_nxt = IDLE_NIB;
    end
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_idx_nxt  = {IDX_W{1'b0}};
    w_pend_nxt = 1'b0;
    if ((r_state == ST_DATA) && (w_state_nxt == ST_DATA)) begin
      w_pend_nxt = w_retrain_req;
      if (w_load) begin
        w_busy_nxt = 1'b1;
        w_idx_nxt  = {IDX_W{1'b0}};
      end else if (w_shift) begin
        w_busy_nxt = 1'b1;
        w_idx_nxt  = (r_idx == NIB_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
      end else begin
        w_busy_nxt = 1'b0;
        w_idx_nxt  = {IDX_W{1'b0}};
      end
    end else begin
      w_busy_nxt = 1'b0;
    end
    w_ready_nxt = (w_state_nxt == ST_DATA) && (!w_busy_nxt || (w_idx_nxt == NIB_LAST)) && !w_pend_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_din       <= IDLE_NIB;
      r_s_ready   <= 1'b0;
      r_underflow <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_pend      <= 1'b0;
      r_word      <= {WORD_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_pat       <= PAT_ALT;
    end else begin
      r_din     <= w_din_nxt;
      r_s_ready <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_idx     <= w_idx_nxt;
      r_pend    <= w_pend_nxt;
      // A fresh underflow beats a simultaneous clear.
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end else if (i_clr_underflow) begin
        r_underflow <= 1'b0;
      end else begin
        r_underflow <= r_underflow;
      end
      if (w_enter) begin
        r_cnt <= (i_train_len == {CNT_W{1'b0}}) ? CNT_W'(1) : i_train_len;
        r_pat <= pat_t'(i_pat_sel);
      end else if (w_train_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_load) begin
        r_word <= {4'b0000, i_s_data[WORD_W-1:4]};
      end else if (w_shift) begin
        r_word <= {4'b0000, r_word[WORD_W-1:4]};
      end else begin
        r_word <= r_word;
      end
    end
  end

  assign o_din       = r_din;
  assign o_s_ready   = r_s_ready;
  assign o_underflow = r_underflow;
  assign o_state     = r_state;

endmodule
